uart_rx_os: RTL
===============

Name: uart_rx_os

Overview:
- UART receive stage that consumes the oversampling tick from the baud-rate generator (16 ticks per bit period).
- Synchronises the serial line, detects and validates the start bit, and samples data, optional parity and stop bits at bit centres.
- Presents each received word with a one-cycle done pulse and error flags to the downstream FIFO/interface.

Parameters:
- DBIT, 8, number of data bits per frame (5..9), LSB first.
- SB_TICK, 16, oversample ticks spanned by the stop period (16 = 1 stop bit, 24 = 1.5, 32 = 2).
- PARITY_EN, 0, 1 = a parity bit follows the data bits.
- PARITY_ODD, 0, 1 = odd parity, 0 = even; ignored when PARITY_EN = 0.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- s_tick  in  1  oversample enable, one clk wide, 16 per bit period.
- rx  in  1  asynchronous serial line, idle high.
- rx_dout  out  DBIT  last received data word.
- rx_done  out  1  one-clk pulse: frame complete, rx_dout and flags valid.
- frame_err  out  1  stop bit sampled low on last frame.
- parity_err  out  1  parity mismatch on last frame (always 0 when PARITY_EN = 0).
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset:
  - While reset_n = 0 at a clk edge: state = IDLE; counters = 0; synchroniser flops = 1.
  - rx_dout = 0, rx_done = 0, frame_err = 0, parity_err = 0, busy = 0.
  - Reset mid-frame aborts the frame with no rx_done.
- Synchroniser: rx passes through 2 flops to give rx_s. All decisions use rx_s, so there are 2 clk of line latency.
- Counters: s_cnt counts s_tick (width = clog2(SB_TICK)); n_cnt counts data bits. Counters advance only on clk edges where s_tick = 1.
- IDLE:
  - rx_s = 0 (checked every clk, independent of s_tick) -> START, s_cnt = 0.
- START:
  - On s_tick with s_cnt = 7 (mid start bit): if rx_s = 0 -> DATA, s_cnt = 0, n_cnt = 0, parity accumulator cleared. If rx_s = 1 -> IDLE (glitch rejected, no outputs change).
  - Otherwise s_cnt++ on s_tick.
- DATA:
  - On s_tick with s_cnt = 15: s_cnt = 0; shift register = {rx_s, shreg[DBIT-1:1]}; parity accumulator ^= rx_s.
  - If n_cnt = DBIT-1 -> PARITY (PARITY_EN = 1) or STOP; else n_cnt++.
  - Otherwise s_cnt++ on s_tick.
- PARITY:
  - On s_tick with s_cnt = 15: s_cnt = 0; latch perr = (acc ^ rx_s ^ PARITY_ODD); -> STOP.
- STOP:
  - On s_tick with s_cnt = SB_TICK-1, in the same edge:
    - rx_done <= 1; rx_dout <= shreg.
    - frame_err <= ~rx_s.
    - parity_err <= perr, or 0 when PARITY_EN = 0.
    - -> IDLE.
  - Otherwise s_cnt++.
- Output timing:
  - rx_done is high exactly the one clk after that edge and low otherwise.
  - rx_dout and the error flags hold until the next rx_done.
- Frame handling:
  - A framing error still delivers rx_dout.
  - A line held low after a bad stop bit re-enters START from IDLE on the next clk and is treated as a new start bit.
- Counter wrap: s_cnt never exceeds 15 in START/DATA/PARITY or SB_TICK-1 in STOP; no modular wrap is relied on.
- Simultaneous events: reset_n = 0 overrides s_tick and rx on the same edge. rx changes during a non-tick cycle have no effect outside IDLE.
- busy = (state != IDLE), registered with the state.

Test Plan:
- s_tick every 4 clk; send 0xA5, 8N1, bit period 64 clk -> one rx_done pulse, rx_dout = 0xA5, frame_err = 0, parity_err = 0, busy low after the pulse.
- rx low for 5 s_ticks then high -> returns to IDLE from START, no rx_done, rx_dout unchanged, busy pulses then clears.
- Send 0x3C with stop bit forced 0 -> rx_done, rx_dout = 0x3C, frame_err = 1. Next clean frame 0x00 -> frame_err = 0.
- PARITY_EN = 1, PARITY_ODD = 0: send 0x01 with parity bit 0 -> parity_err = 1. Send 0x03 with parity bit 0 -> parity_err = 0. Repeat with PARITY_ODD = 1 -> flags invert.
- Assert reset_n = 0 for 1 clk during data bit 4 -> all outputs 0, no rx_done. Subsequent 0x5A frame received correctly.
- Back-to-back frames 0xFF, 0x00, 0x81 with no idle gap, SB_TICK = 16 -> three rx_done pulses exactly 10 bit periods apart, data in order, no errors.

Source files
------------

// File: rtl/uart_rx_os_if.sv
// Serial-receive bundle: line and oversample tick in, received word and status out.
interface uart_rx_os_if #(
    parameter int DBIT = 8
);
    logic            s_tick;
    logic            rx;
    logic [DBIT-1:0] rx_dout;
    logic            rx_done;
    logic            frame_err;
    logic            parity_err;
    logic            busy;

    modport master (
        output s_tick, rx,
        input  rx_dout, rx_done, frame_err, parity_err, busy
    );

    modport slave (
        input  s_tick, rx,
        output rx_dout, rx_done, frame_err, parity_err, busy
    );
endinterface

// File: rtl/uart_rx_os.sv
// UART receiver on a 16x oversample tick: start-bit validation, centre sampling of
// data/parity/stop, one-clk done pulse with sticky word and error flags.
module uart_rx_os #(
    parameter int DBIT       = 8,
    parameter int SB_TICK    = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic         clk,
    input  logic         reset_n,
    uart_rx_os_if.slave  bus
);
    // s_cnt must reach 15 in every state, and SB_TICK-1 in STOP
    localparam int CW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [CW-1:0] MID_TICK  = CW'(7);
    localparam logic [CW-1:0] LAST_TICK = CW'(15);
    localparam logic [CW-1:0] STOP_LAST = CW'(SB_TICK - 1);
    localparam logic [NW-1:0] LAST_BIT  = NW'(DBIT - 1);
    localparam logic          PAR_EN    = (PARITY_EN != 0);
    localparam logic          PAR_ODD   = (PARITY_ODD != 0);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic [2:0]      state;
    logic [CW-1:0]   s_cnt;
    logic [NW-1:0]   n_cnt;
    logic [DBIT-1:0] shreg;
    logic            acc;
    logic            perr;
    logic            rx_m;
    logic            rx_s;
    logic [DBIT-1:0] dout_r;
    logic            done_r;
    logic            ferr_r;
    logic            perr_r;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= IDLE;
            s_cnt  <= '0;
            n_cnt  <= '0;
            shreg  <= '0;
            acc    <= 1'b0;
            perr   <= 1'b0;
            rx_m   <= 1'b1;
            rx_s   <= 1'b1;
            dout_r <= '0;
            done_r <= 1'b0;
            ferr_r <= 1'b0;
            perr_r <= 1'b0;
        end else begin
            rx_m   <= bus.rx;
            rx_s   <= rx_m;
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        s_cnt <= '0;
                    end
                end
                START: begin
                    if (bus.s_tick) begin
                        if (s_cnt == MID_TICK) begin
                            // a start bit that is high again at its centre was a glitch
                            if (!rx_s) begin
                                state <= DATA;
                                s_cnt <= '0;
                                n_cnt <= '0;
                                acc   <= 1'b0;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            s_cnt <= s_cnt + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (bus.s_tick) begin
                        if (s_cnt == LAST_TICK) begin
                            s_cnt <= '0;
                            shreg <= {rx_s, shreg[DBIT-1:1]};
                            acc   <= acc ^ rx_s;
                            if (n_cnt == LAST_BIT)
                                state <= PAR_EN ? PARITY : STOP;
                            else
                                n_cnt <= n_cnt + 1'b1;
                        end else begin
                            s_cnt <= s_cnt + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (bus.s_tick) begin
                        if (s_cnt == LAST_TICK) begin
                            s_cnt <= '0;
                            perr  <= acc ^ rx_s ^ PAR_ODD;
                            state <= STOP;
                        end else begin
                            s_cnt <= s_cnt + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (bus.s_tick) begin
                        if (s_cnt == STOP_LAST) begin
                            done_r <= 1'b1;
                            dout_r <= shreg;
                            ferr_r <= ~rx_s;
                            perr_r <= PAR_EN & perr;
                            state  <= IDLE;
                        end else begin
                            s_cnt <= s_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rx_dout    = dout_r;
    assign bus.rx_done    = done_r;
    assign bus.frame_err  = ferr_r;
    assign bus.parity_err = perr_r;
    assign bus.busy       = (state != IDLE);
endmodule
